multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/seq_pkg.sv | 31 +++
 rtl/seq_wait_timer.sv | 32 +++
 rtl/multicycle_sequencer.sv | 136 +++++++++++++
 tb/tb_multicycle_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle sequencer: state encoding, opcodes, state decode.
// Latency: n/a (package). Backpressure: n/a.
// Unused encoding 7 decodes to FAULT so a corrupted state register fails safe.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5,
        ST_FAULT  = 3'd6
    } seq_state_e;

    localparam logic [2:0] S_FETCH  = ST_FETCH;
    localparam logic [2:0] S_DECODE = ST_DECODE;
    localparam logic [2:0] S_EXEC   = ST_EXEC;
    localparam logic [2:0] S_MEM    = ST_MEM;
    localparam logic [2:0] S_WB     = ST_WB;
    localparam logic [2:0] S_HALTED = ST_HALTED;
    localparam logic [2:0] S_FAULT  = ST_FAULT;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    function automatic logic [2:0] state_decode(input logic [2:0] raw);
        return (raw == 3'd7) ? S_FAULT : raw;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory handshake wait counter with timeout detect; cleared on every state entry.
// Latency: timeout_hit is combinational on the cycle the count would reach TIMEOUT.
// Backpressure: none; wait_en advances the count, clear has priority over it.
module seq_wait_timer
    import seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       wait_en,
    output logic [7:0] wait_cnt,
    output logic       timeout_hit
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (wait_en) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Only a cycle without Ready can time out, so Ready on the last cycle wins.
    assign timeout_hit = wait_en && (wait_cnt == LAST_WAIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer FSM (FETCH/DECODE/EXEC/MEM/WB/HALTED/FAULT); SEQ_PERF_CNT_EN adds perf counters.
// Latency: 4 cycles ALU/store, 5 cycles load with zero-wait memory; strobes are one cycle.
// Backpressure: IMReq/DMReq held until the matching Ready; no Ready within TIMEOUT cycles -> sticky FAULT.
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  OpCode,
    input  logic        RUWr,
    input  logic        DMWr,
    input  logic        Halt,
    input  logic        IMReady,
    input  logic        DMReady,
    output logic        IMReq,
    output logic        DMReq,
    output logic        IRWr,
    output logic        PCWr,
    output logic        RUWrEn,
    output logic        DMWrEn,
    output logic [2:0]  State,
    output logic        Fault,
    output logic [31:0] CycleCnt,
    output logic [31:0] InstRet
);
    import seq_pkg::*;

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [2:0] cur;
    logic [7:0] wait_cnt;
    logic       timeout_hit;
    logic       wait_en;
    logic       is_store;
    logic       is_mem_op;
    logic       fetch_halt;
    logic       in_fetch;
    logic       in_mem;
    logic       in_wb;

    assign cur       = state_decode(state_q);
    assign in_fetch  = (cur == S_FETCH);
    assign in_mem    = (cur == S_MEM);
    assign in_wb     = (cur == S_WB);
    assign is_store  = (OpCode == STORE);
    assign is_mem_op = (OpCode == LOAD) || is_store;

    // A zero wait count in FETCH means the cycle of entry, before any request went out.
    assign fetch_halt = in_fetch && Halt && (wait_cnt == 8'd0);

    // Outputs are masked while reset is held so nothing is requested or strobed.
    assign IMReq  = !rst && in_fetch && !fetch_halt;
    assign DMReq  = !rst && in_mem;
    assign IRWr   = IMReq && IMReady;
    assign DMWrEn = DMReq && DMWr;
    assign RUWrEn = !rst && in_wb && RUWr;
    assign PCWr   = !rst && (in_wb || (in_mem && DMReady && is_store));
    assign Fault  = !rst && (cur == S_FAULT);
    assign State  = state_q;

    assign wait_en = (IMReq && !IMReady) || (DMReq && !DMReady);

    always_comb begin
        state_d = cur;
        case (cur)
            S_FETCH: begin
                if (fetch_halt) begin
                    state_d = S_HALTED;
                end else if (IMReady) begin
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = is_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                if (DMReady) begin
                    state_d = is_store ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALTED: begin
                if (!Halt) begin
                    state_d = S_FETCH;
                end
            end
            default:  state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    seq_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (state_d != state_q),
        .wait_en    (wait_en),
        .wait_cnt   (wait_cnt),
        .timeout_hit(timeout_hit)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] inst_ret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            inst_ret_q  <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (PCWr) begin
                inst_ret_q <= inst_ret_q + 32'd1;
            end
        end
    end

    assign CycleCnt = cycle_cnt_q;
    assign InstRet  = inst_ret_q;
`else
    assign CycleCnt = '0;
    assign InstRet  = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer (TIMEOUT=4): directed instructions, strobe scoreboard, timeout/halt/reset.
// Expected strobe events are queued by the stimulus and popped by a negedge monitor.
module tb_multicycle_sequencer;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  OpCode;
    logic        RUWr, DMWr, Halt, IMReady, DMReady;
    logic        IMReq, DMReq, IRWr, PCWr, RUWrEn, DMWrEn;
    logic [2:0]  State;
    logic        Fault;
    logic [31:0] CycleCnt, InstRet;

    multicycle_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .RUWr(RUWr), .DMWr(DMWr), .Halt(Halt),
        .IMReady(IMReady), .DMReady(DMReady), .IMReq(IMReq), .DMReq(DMReq),
        .IRWr(IRWr), .PCWr(PCWr), .RUWrEn(RUWrEn), .DMWrEn(DMWrEn),
        .State(State), .Fault(Fault), .CycleCnt(CycleCnt), .InstRet(InstRet)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         stamp;
        logic [2:0] st;
        logic       irwr;
        logic       pcwr;
        logic       ruwren;
        logic       dmwren;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int stamp, input logic [2:0] st, input logic irwr,
                           input logic pcwr, input logic ruwren, input logic dmwren);
        ev_t e;
        e.stamp = stamp; e.st = st; e.irwr = irwr;
        e.pcwr = pcwr; e.ruwren = ruwren; e.dmwren = dmwren;
        exp_q.push_back(e);
    endtask

    // Monitor: every datapath strobe cycle must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && (IRWr || PCWr || RUWrEn || DMWrEn)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got cyc=%0d st=%0d irwr=%b pcwr=%b ruwren=%b dmwren=%b, expected no strobe",
                         cyc, State, IRWr, PCWr, RUWrEn, DMWrEn);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.stamp != cyc || mon_e.st !== State || mon_e.irwr !== IRWr ||
                    mon_e.pcwr !== PCWr || mon_e.ruwren !== RUWrEn || mon_e.dmwren !== DMWrEn) begin
                    errors++;
                    $display("FAIL strobe_event: got cyc=%0d st=%0d irwr=%b pcwr=%b ruwren=%b dmwren=%b, expected cyc=%0d st=%0d irwr=%b pcwr=%b ruwren=%b dmwren=%b",
                             cyc, State, IRWr, PCWr, RUWrEn, DMWrEn,
                             mon_e.stamp, mon_e.st, mon_e.irwr, mon_e.pcwr, mon_e.ruwren, mon_e.dmwren);
                end
            end
        end
    end

    // Runs one instruction from the first cycle of FETCH; dw = DMReady wait cycles in MEM.
    task automatic do_inst(input logic [6:0] op, input logic ruwr, input logic dmwr,
                           input int dw, input logic halt_exec);
        int         base;
        int         len;
        int         dmreq_n;
        logic       is_st;
        logic       is_mem;
        logic [2:0] st;
        base   = cyc;
        is_st  = (op == OP_SW);
        is_mem = is_st || (op == OP_LW);
        len    = !is_mem ? 4 : (is_st ? 4 + dw : 5 + dw);
        OpCode = op; RUWr = ruwr; DMWr = dmwr; IMReady = 1'b1;
        push_ev(base, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        if (is_mem) begin
            for (int k = 3; k <= 3 + dw; k++) begin
                if (dmwr || (is_st && k == 3 + dw))
                    push_ev(base + k, 3'd3, 1'b0, is_st && (k == 3 + dw), 1'b0, dmwr);
            end
        end
        if (!is_st) push_ev(base + len - 1, 3'd4, 1'b0, 1'b1, ruwr, 1'b0);
        dmreq_n = 0;
        for (int k = 0; k < len; k++) begin
            DMReady = (k >= 3 + dw);
            if (halt_exec && k == 2) Halt = 1'b1;
            st = (k < 3) ? 3'(k) : ((is_mem && k <= 3 + dw) ? 3'd3 : 3'd4);
            @(negedge clk);
            check("state_trace", 32'(State), 32'(st));
            if (DMReq) dmreq_n++;
            @(posedge clk); #1;
        end
        check("dmreq_cycles", dmreq_n, is_mem ? dw + 1 : 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_cyc;
        int exp_ret;
        rst = 1'b1; OpCode = '0; RUWr = 0; DMWr = 0; Halt = 0; IMReady = 0; DMReady = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(State), 0);
        check("reset_imreq", 32'(IMReq), 0);
        check("reset_dmreq", 32'(DMReq), 0);
        check("reset_fault", 32'(Fault), 0);
        check("reset_cyclecnt", CycleCnt, 0);
        check("reset_instret", InstRet, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_inst(OP_ADD, 1'b1, 1'b0, 0, 1'b0);
        do_inst(OP_LW,  1'b1, 1'b0, 3, 1'b0);   // Ready on the cycle the count hits TIMEOUT
        do_inst(OP_SW,  1'b1, 1'b1, 1, 1'b0);
        do_inst(OP_BEQ, 1'b0, 1'b0, 0, 1'b0);
        do_inst(OP_ADD, 1'b1, 1'b0, 0, 1'b1);   // Halt raised during EXEC

        @(negedge clk);
        check("halt_fetch_state", 32'(State), 0);
        check("halt_fetch_noreq", 32'(IMReq), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("halted_state", 32'(State), 5);
        check("halted_noreq", 32'(IMReq), 0);
        @(posedge clk); #1;
        Halt = 1'b0;
        @(negedge clk);
        check("halted_hold", 32'(State), 5);
        @(posedge clk); #1;
        do_inst(OP_LUI, 1'b1, 1'b0, 0, 1'b0);

        IMReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("timeout_wait_state", 32'(State), 0);
            check("timeout_wait_imreq", 32'(IMReq), 1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("fault_state", 32'(State), 6);
        check("fault_flag", 32'(Fault), 1);
        check("fault_noreq", 32'(IMReq), 0);
        IMReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("fault_sticky", 32'(Fault), 1);
            check("fault_sticky_state", 32'(State), 6);
        end

        #2 rst = 1'b1;
        #1;
        check("async_reset_state", 32'(State), 0);
        check("async_reset_fault", 32'(Fault), 0);
        check("async_reset_imreq", 32'(IMReq), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_reset_imreq", 32'(IMReq), 1);

        for (int i = 0; i < 10; i++) do_inst(OP_ADD, 1'b1, 1'b0, 0, 1'b0);
        IMReady = 1'b0;
`ifdef SEQ_PERF_CNT_EN
        exp_cyc = 40; exp_ret = 10;
`else
        exp_cyc = 0;  exp_ret = 0;
`endif
        check("perf_cyclecnt", CycleCnt, 32'(exp_cyc));
        check("perf_instret", InstRet, 32'(exp_ret));
        check("scoreboard_drained", exp_q.size(), 0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
